// File: rtl/npe_topk_pkg.sv
// rtl/npe_topk_pkg.sv - shared state encoding and element compare for the top-K selector
package npe_topk_pkg;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] LOAD = 2'd1;
    localparam logic [1:0] OUT  = 2'd2;

    localparam int CMP_W = 64;

    // Flipping the sign bit maps two's complement onto offset binary, so one
    // unsigned compare serves both modes. Operands arrive zero-extended.
    function automatic logic val_gt(input logic [CMP_W-1:0] a,
                                    input logic [CMP_W-1:0] b,
                                    input logic [5:0]       msb,
                                    input logic             sgn);
        logic [CMP_W-1:0] flip;
        flip      = '0;
        flip[msb] = sgn;
        return (a ^ flip) > (b ^ flip);
    endfunction

endpackage

// File: rtl/npe_topk_slot.sv
// rtl/npe_topk_slot.sv - one entry of the sorted top-K list with its compare and shift-in mux
module npe_topk_slot
    import npe_topk_pkg::*;
#(
    parameter int DATA_WIDTH  = 8,
    parameter int INDEX_WIDTH = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   clear,
    input  logic                   load,
    input  logic                   sgn,
    input  logic [DATA_WIDTH-1:0]  elem_val,
    input  logic [INDEX_WIDTH-1:0] elem_idx,
    input  logic [DATA_WIDTH-1:0]  prev_val,
    input  logic [INDEX_WIDTH-1:0] prev_idx,
    input  logic                   prev_occ,
    input  logic                   prev_ins,
    output logic [DATA_WIDTH-1:0]  val,
    output logic [INDEX_WIDTH-1:0] idx,
    output logic                   occ,
    output logic                   ins,
    output logic [DATA_WIDTH-1:0]  nxt_val,
    output logic [INDEX_WIDTH-1:0] nxt_idx,
    output logic                   nxt_occ
);

    // Strictly greater keeps an equal older entry ahead of the new element.
    assign ins = !occ || val_gt(CMP_W'(elem_val), CMP_W'(val), 6'(DATA_WIDTH-1), sgn);

    always_comb begin
        nxt_val = val;
        nxt_idx = idx;
        nxt_occ = occ;
        if (load && prev_ins) begin
            nxt_val = prev_val;
            nxt_idx = prev_idx;
            nxt_occ = prev_occ;
        end else if (load && ins) begin
            nxt_val = elem_val;
            nxt_idx = elem_idx;
            nxt_occ = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            val <= '0;
            idx <= '0;
            occ <= 1'b0;
        end else if (clear) begin
            val <= '0;
            idx <= '0;
            occ <= 1'b0;
        end else begin
            val <= nxt_val;
            idx <= nxt_idx;
            occ <= nxt_occ;
        end
    end

endmodule

// File: rtl/npe_topk.sv
// rtl/npe_topk.sv - streaming top-K selector: serialises beats into a sorted list, then emits it
module npe_topk
    import npe_topk_pkg::*;
#(
    parameter int DATA_WIDTH  = 8,
    parameter int DATA_COPIES = 32,
    parameter int TOPK        = 5,
    parameter int INDEX_WIDTH = 16,
    parameter int CNT_WIDTH   = 6
) (
    input  logic                              i_clk,
    input  logic                              i_rst_n,
    input  logic                              i_clear,
    input  logic                              i_signed,
    input  logic [DATA_COPIES*DATA_WIDTH-1:0] i_data,
    input  logic                              i_data_vld,
    output logic                              o_data_rdy,
    input  logic                              i_last,
    input  logic [CNT_WIDTH-1:0]              i_lane_cnt,
    output logic [DATA_WIDTH-1:0]             o_res_data,
    output logic [INDEX_WIDTH-1:0]            o_res_idx,
    output logic                              o_res_vld,
    input  logic                              i_res_rdy,
    output logic                              o_res_last,
    output logic                              o_idx_ovf
);

    localparam int LANE_N = 2**CNT_WIDTH;
    localparam int PTR_W  = $clog2(TOPK+1);
    localparam int NSEL   = 2**PTR_W;

    logic [1:0]                        state, nxt_state;
    logic [DATA_COPIES*DATA_WIDTH-1:0] beat;
    logic                              beat_sgn, beat_last;
    logic [CNT_WIDTH-1:0]              lane_cnt, lane_ptr;
    logic [INDEX_WIDTH-1:0]            cnt;
    logic                              cnt_full, idx_ovf;
    logic [PTR_W-1:0]                  out_ptr, nxt_ptr;
    logic                              data_rdy, nxt_rdy;
    logic                              res_vld, nxt_vld, res_last, nxt_last;
    logic [DATA_WIDTH-1:0]             res_data, nxt_data;
    logic [INDEX_WIDTH-1:0]            res_idx, nxt_idx;

    logic accept, final_lane, res_hs, done, load_en, slot_clear;
    logic [DATA_WIDTH-1:0] lanes [LANE_N];

    logic [DATA_WIDTH-1:0]  c_val [TOPK+1];
    logic [INDEX_WIDTH-1:0] c_idx [TOPK+1];
    logic                   c_occ [TOPK+1];
    logic                   c_ins [TOPK+1];
    logic [DATA_WIDTH-1:0]  n_val [NSEL];
    logic [INDEX_WIDTH-1:0] n_idx [NSEL];
    logic                   n_occ [NSEL];

    assign accept     = i_data_vld && data_rdy;
    assign final_lane = (lane_ptr == lane_cnt - CNT_WIDTH'(1));
    assign res_hs     = res_vld && i_res_rdy;
    assign done       = (state == OUT) && res_hs && res_last;
    assign load_en    = (state == LOAD) && !i_clear;
    assign slot_clear = i_clear || done;

    for (genvar l = 0; l < LANE_N; l++) begin : g_lane
        if (l < DATA_COPIES) begin : g_real
            assign lanes[l] = beat[l*DATA_WIDTH +: DATA_WIDTH];
        end else begin : g_pad
            assign lanes[l] = '0;
        end
    end

    assign c_val[0] = '0;
    assign c_idx[0] = '0;
    assign c_occ[0] = 1'b0;
    assign c_ins[0] = 1'b0;

    for (genvar k = 0; k < TOPK; k++) begin : g_slot
        npe_topk_slot #(.DATA_WIDTH(DATA_WIDTH), .INDEX_WIDTH(INDEX_WIDTH)) u_slot (
            .clk(i_clk), .rst_n(i_rst_n), .clear(slot_clear), .load(load_en),
            .sgn(beat_sgn), .elem_val(lanes[lane_ptr]), .elem_idx(cnt),
            .prev_val(c_val[k]), .prev_idx(c_idx[k]), .prev_occ(c_occ[k]), .prev_ins(c_ins[k]),
            .val(c_val[k+1]), .idx(c_idx[k+1]), .occ(c_occ[k+1]), .ins(c_ins[k+1]),
            .nxt_val(n_val[k]), .nxt_idx(n_idx[k]), .nxt_occ(n_occ[k])
        );
    end

    // Empty padding lets the "is the next slot occupied" lookup run past TOPK-1.
    for (genvar k = TOPK; k < NSEL; k++) begin : g_npad
        assign n_val[k] = '0;
        assign n_idx[k] = '0;
        assign n_occ[k] = 1'b0;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) state <= IDLE;
        else          state <= nxt_state;
    end

    always_comb begin
        nxt_state = state;
        case (state)
            IDLE:    if (accept) nxt_state = LOAD;
            LOAD:    if (final_lane) nxt_state = beat_last ? OUT : IDLE;
            OUT:     if (res_hs && res_last) nxt_state = IDLE;
            default: nxt_state = IDLE;
        endcase
        if (i_clear) nxt_state = IDLE;
    end

    // Entering OUT reads the slot next-values so slot 0 already holds the final insertion.
    always_comb begin
        nxt_rdy  = (nxt_state == IDLE);
        nxt_vld  = res_vld;
        nxt_last = res_last;
        nxt_data = res_data;
        nxt_idx  = res_idx;
        nxt_ptr  = out_ptr;
        if (i_clear) begin
            nxt_vld  = 1'b0;
            nxt_last = 1'b0;
        end else if (state == LOAD && final_lane && beat_last) begin
            nxt_vld  = 1'b1;
            nxt_ptr  = '0;
            nxt_data = n_val[0];
            nxt_idx  = n_idx[0];
            nxt_last = !n_occ[1];
        end else if (state == OUT && res_hs) begin
            if (res_last) begin
                nxt_vld  = 1'b0;
                nxt_last = 1'b0;
            end else begin
                nxt_ptr  = out_ptr + PTR_W'(1);
                nxt_data = n_val[out_ptr + PTR_W'(1)];
                nxt_idx  = n_idx[out_ptr + PTR_W'(1)];
                nxt_last = !n_occ[out_ptr + PTR_W'(2)];
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            data_rdy <= 1'b1;
            res_vld  <= 1'b0;
            res_last <= 1'b0;
            res_data <= '0;
            res_idx  <= '0;
            out_ptr  <= '0;
        end else begin
            data_rdy <= nxt_rdy;
            res_vld  <= nxt_vld;
            res_last <= nxt_last;
            res_data <= nxt_data;
            res_idx  <= nxt_idx;
            out_ptr  <= nxt_ptr;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            beat      <= '0;
            beat_sgn  <= 1'b0;
            beat_last <= 1'b0;
            lane_cnt  <= '0;
            lane_ptr  <= '0;
        end else if (accept && !i_clear) begin
            beat      <= i_data;
            beat_sgn  <= i_signed;
            beat_last <= i_last;
            lane_cnt  <= (i_last && i_lane_cnt != '0) ? i_lane_cnt : CNT_WIDTH'(DATA_COPIES);
            lane_ptr  <= '0;
        end else if (state == LOAD) begin
            lane_ptr  <= lane_ptr + CNT_WIDTH'(1);
        end
    end

    // cnt_full marks that the all-ones index has been handed out once already.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cnt      <= '0;
            cnt_full <= 1'b0;
            idx_ovf  <= 1'b0;
        end else if (slot_clear) begin
            cnt      <= '0;
            cnt_full <= 1'b0;
            idx_ovf  <= 1'b0;
        end else if (state == LOAD) begin
            if (cnt_full)  idx_ovf  <= 1'b1;
            else if (&cnt) cnt_full <= 1'b1;
            else           cnt      <= cnt + INDEX_WIDTH'(1);
        end
    end

    assign o_data_rdy = data_rdy;
    assign o_res_vld  = res_vld;
    assign o_res_last = res_last;
    assign o_res_data = res_data;
    assign o_res_idx  = res_idx;
    assign o_idx_ovf  = idx_ovf;

endmodule

// File: tb/tb_npe_topk.sv
// tb/tb_npe_topk.sv - directed-vector bench for npe_topk (TOPK=3 and TOPK=5/INDEX_WIDTH=3 instances)
module tb_npe_topk;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, clear, sgn, last, data_vld, res_rdy;
    logic [31:0] data;
    logic [2:0]  lane_cnt;
    int          sel;

    logic       rdy_a, vld_a, last_a, ovf_a;
    logic [7:0] dat_a;
    logic [15:0] idx_a;
    logic       rdy_b, vld_b, last_b, ovf_b;
    logic [7:0] dat_b;
    logic [2:0] idx_b;

    npe_topk #(.DATA_WIDTH(8), .DATA_COPIES(4), .TOPK(3), .INDEX_WIDTH(16), .CNT_WIDTH(3)) u_k3 (
        .i_clk(clk), .i_rst_n(rst_n), .i_clear(clear), .i_signed(sgn), .i_data(data),
        .i_data_vld(data_vld && sel == 0), .o_data_rdy(rdy_a), .i_last(last), .i_lane_cnt(lane_cnt),
        .o_res_data(dat_a), .o_res_idx(idx_a), .o_res_vld(vld_a), .i_res_rdy(res_rdy && sel == 0),
        .o_res_last(last_a), .o_idx_ovf(ovf_a));

    npe_topk #(.DATA_WIDTH(8), .DATA_COPIES(4), .TOPK(5), .INDEX_WIDTH(3), .CNT_WIDTH(3)) u_k5 (
        .i_clk(clk), .i_rst_n(rst_n), .i_clear(clear), .i_signed(sgn), .i_data(data),
        .i_data_vld(data_vld && sel == 1), .o_data_rdy(rdy_b), .i_last(last), .i_lane_cnt(lane_cnt),
        .o_res_data(dat_b), .o_res_idx(idx_b), .o_res_vld(vld_b), .i_res_rdy(res_rdy && sel == 1),
        .o_res_last(last_b), .o_idx_ovf(ovf_b));

    logic        m_rdy, m_vld, m_last, m_ovf;
    logic [7:0]  m_data;
    logic [15:0] m_idx;
    assign m_rdy  = (sel == 0) ? rdy_a  : rdy_b;
    assign m_vld  = (sel == 0) ? vld_a  : vld_b;
    assign m_last = (sel == 0) ? last_a : last_b;
    assign m_ovf  = (sel == 0) ? ovf_a  : ovf_b;
    assign m_data = (sel == 0) ? dat_a  : dat_b;
    assign m_idx  = (sel == 0) ? idx_a  : {13'd0, idx_b};

    int n_vec = 0;
    int n_bad = 0;
    logic [7:0]  exp_val [$];
    logic [15:0] exp_idx [$];
    int          rdy_pat [$];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_beat(input logic [31:0] d, input logic l, input logic [2:0] c, input logic s);
        int n;
        data = d; last = l; lane_cnt = c; sgn = s; data_vld = 1'b1;
        n = 0;
        while (!m_rdy && n < 50) begin
            tick();
            n++;
        end
        if (!m_rdy) check_eq("rdy_timeout", 0, 1);
        tick();
        data_vld = 1'b0; last = 1'b0;
    endtask

    task automatic wait_vld(input string tag);
        int n;
        n = 0;
        while (!m_vld && n < 50) begin
            tick();
            n++;
        end
        if (!m_vld) check_eq({tag, "_vld_timeout"}, 0, 1);
    endtask

    task automatic collect(input string tag);
        int k, g, p;
        k = 0; g = 0; p = 0;
        while (k < exp_val.size() && g < 200) begin
            if (m_vld) begin
                res_rdy = (rdy_pat.size() == 0) ? 1'b1 : rdy_pat[p % rdy_pat.size()] != 0;
                p++;
                check_eq({tag, "_val"}, m_data, exp_val[k]);
                check_eq({tag, "_idx"}, m_idx, exp_idx[k]);
                check_eq({tag, "_last"}, m_last, k == exp_val.size() - 1);
                if (res_rdy) k++;
            end else begin
                res_rdy = 1'b0;
            end
            tick();
            g++;
        end
        res_rdy = 1'b0;
        check_eq({tag, "_count"}, k, exp_val.size());
        check_eq({tag, "_vld_after"}, m_vld, 0);
        check_eq({tag, "_rdy_after"}, m_rdy, 1);
        rdy_pat = {};
    endtask

    initial begin
        int lat;
        rst_n = 1'b0; clear = 1'b0; sgn = 1'b0; last = 1'b0; data_vld = 1'b0;
        res_rdy = 1'b0; data = '0; lane_cnt = '0; sel = 0;
        tick(); tick();
        check_eq("rst_rdy", m_rdy, 1);
        check_eq("rst_vld", m_vld, 0);
        check_eq("rst_last", m_last, 0);
        check_eq("rst_data", m_data, 0);
        check_eq("rst_idx", m_idx, 0);
        check_eq("rst_ovf", m_ovf, 0);
        rst_n = 1'b1;
        tick();

        // {5,9,2,9}: ties keep the older index first, latency to first result
        send_beat(32'h09020905, 1'b1, 3'd0, 1'b0);
        lat = 1;
        while (!m_vld && lat < 20) begin
            tick();
            lat++;
        end
        check_eq("latency", lat, 5);
        check_eq("rdy_in_out", m_rdy, 0);
        exp_val = '{8'h09, 8'h09, 8'h05};
        exp_idx = '{16'd1, 16'd3, 16'd0};
        collect("basic");

        // signed with a stalling consumer
        send_beat(32'h01FF7F80, 1'b1, 3'd0, 1'b1);
        exp_val = '{8'h7F, 8'h01, 8'hFF};
        exp_idx = '{16'd1, 16'd3, 16'd2};
        rdy_pat = '{1, 0, 0, 1};
        collect("signed");

        send_beat(32'h01FF7F80, 1'b1, 3'd0, 1'b0);
        exp_val = '{8'hFF, 8'h80, 8'h7F};
        exp_idx = '{16'd2, 16'd0, 16'd1};
        collect("unsigned");

        // two beats, last one carries a single lane
        sel = 1;
        send_beat(32'h281E140A, 1'b0, 3'd0, 1'b0);
        check_eq("rdy_load", m_rdy, 0);
        repeat (4) tick();
        check_eq("rdy_back", m_rdy, 1);
        send_beat(32'h6363630F, 1'b1, 3'd1, 1'b0);
        exp_val = '{8'd40, 8'd30, 8'd20, 8'd15, 8'd10};
        exp_idx = '{16'd3, 16'd2, 16'd1, 16'd4, 16'd0};
        collect("two_beat");

        // short stream below TOPK
        send_beat(32'h63630303, 1'b1, 3'd2, 1'b0);
        exp_val = '{8'd3, 8'd3};
        exp_idx = '{16'd0, 16'd1};
        collect("short");

        // index saturation at 7
        send_beat(32'h04030201, 1'b0, 3'd0, 1'b0);
        send_beat(32'h08070605, 1'b0, 3'd0, 1'b0);
        send_beat(32'h63630A09, 1'b1, 3'd2, 1'b0);
        wait_vld("ovf");
        check_eq("ovf_set", m_ovf, 1);
        exp_val = '{8'd10, 8'd9, 8'd8, 8'd7, 8'd6};
        exp_idx = '{16'd7, 16'd7, 16'd7, 16'd6, 16'd5};
        collect("sat");
        check_eq("ovf_clr", m_ovf, 0);

        // clear mid-LOAD
        sel = 0;
        send_beat(32'h04030201, 1'b1, 3'd0, 1'b0);
        tick();
        clear = 1'b1;
        tick();
        clear = 1'b0;
        check_eq("clr_load_vld", m_vld, 0);
        check_eq("clr_load_rdy", m_rdy, 1);
        repeat (5) tick();
        check_eq("clr_load_quiet", m_vld, 0);
        send_beat(32'h04030201, 1'b1, 3'd0, 1'b0);
        exp_val = '{8'd4, 8'd3, 8'd2};
        exp_idx = '{16'd3, 16'd2, 16'd1};
        collect("after_clr_load");

        // clear during OUT
        send_beat(32'h04030201, 1'b1, 3'd0, 1'b0);
        wait_vld("clr_out");
        clear = 1'b1;
        tick();
        clear = 1'b0;
        check_eq("clr_out_vld", m_vld, 0);
        check_eq("clr_out_rdy", m_rdy, 1);
        send_beat(32'h07070707, 1'b1, 3'd0, 1'b0);
        exp_val = '{8'd7, 8'd7, 8'd7};
        exp_idx = '{16'd0, 16'd1, 16'd2};
        collect("after_clr_out");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
